// File: rtl/gsim_sched_if.sv
// rtl/gsim_sched_if.sv - b-vector load, solver core and x-result stream bundle for gsim_sched
interface gsim_sched_if;
  logic [15:0] b_in;
  logic        b_valid;
  logic        b_ready;
  logic        core_rst;
  logic        core_in_en;
  logic [15:0] core_b;
  logic        core_out_valid;
  logic [31:0] core_x;
  logic [31:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic        x_last;
  logic [2:0]  x_tag;
  logic        err;
  logic [2:0]  err_tag;

  modport master (
    input  b_in, b_valid, core_out_valid, core_x, x_ready,
    output b_ready, core_rst, core_in_en, core_b,
           x_data, x_valid, x_last, x_tag, err, err_tag
  );

  modport slave (
    output b_in, b_valid, core_out_valid, core_x, x_ready,
    input  b_ready, core_rst, core_in_en, core_b,
           x_data, x_valid, x_last, x_tag, err, err_tag
  );
endinterface

// File: rtl/gsim_sched.sv
// rtl/gsim_sched.sv - round-robin job scheduler for the Gauss-Seidel core; GSIM_SCHED_PERF_EN adds perf_cycles
module gsim_sched #(
  parameter int NREQ    = 2,
  parameter int VEC_LEN = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  gsim_sched_if.master    bus
`ifdef GSIM_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] ILAST = IW'(VEC_LEN - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, CAPT, DRAIN} state_t;

  state_t          state, state_n;
  logic [2:0]      rr_ptr, gidx, sel_idx, rr_nxt;
  logic            sel_found;
  logic [NREQ-1:0] sel_oh;
  logic [IW-1:0]   beat, idx;
  logic [TW-1:0]   tcnt;
  logic [31:0]     xbuf [VEC_LEN];
  logic            core_rst_q, err_q;
  logic [2:0]      err_tag_q;

  logic            b_ready, core_in_en, x_valid, x_last;
  logic [15:0]     core_b;
  logic [31:0]     x_data;
  logic [2:0]      x_tag;

  // First pending requester at or above the rr pointer, wrapping at NREQ.
  always_comb begin
    int k;
    k         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!sel_found && req[k]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(k);
      end
    end
    for (int i = 0; i < NREQ; i++) sel_oh[i] = (sel_idx == 3'(i));
  end

  assign rr_nxt = (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    b_ready    = 1'b0;
    core_in_en = 1'b0;
    core_b     = '0;
    x_valid    = 1'b0;
    x_data     = '0;
    x_last     = 1'b0;
    x_tag      = '0;
    case (state)
      IDLE: if (sel_found) state_n = CLR;
      CLR:  state_n = LOAD;
      LOAD: begin
        b_ready = 1'b1;
        if (bus.b_valid) begin
          core_in_en = 1'b1;
          core_b     = bus.b_in;
          if (beat == ILAST) state_n = RUN;
        end
      end
      RUN: begin
        if (bus.core_out_valid) state_n = CAPT;
        else if (tcnt == TLAST) state_n = IDLE;
      end
      CAPT: if (idx == ILAST) state_n = DRAIN;
      DRAIN: begin
        x_valid = 1'b1;
        x_data  = xbuf[idx];
        x_tag   = gidx;
        x_last  = (idx == ILAST);
        if (bus.x_ready && idx == ILAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt        <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      beat       <= '0;
      idx        <= '0;
      tcnt       <= '0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
      err_tag_q  <= '0;
    end else begin
      core_rst_q <= (state_n == CLR);
      err_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            gidx <= sel_idx;
            gnt  <= sel_oh;
            beat <= '0;
          end
        end
        LOAD: begin
          if (bus.b_valid) begin
            beat <= beat + 1'b1;
            if (beat == ILAST) tcnt <= '0;
          end
        end
        RUN: begin
          tcnt <= tcnt + 1'b1;
          if (bus.core_out_valid) begin
            idx <= IW'(1);
          end else if (tcnt == TLAST) begin
            err_q     <= 1'b1;
            err_tag_q <= gidx;
            gnt       <= '0;
            rr_ptr    <= rr_nxt;
          end
        end
        CAPT: idx <= (idx == ILAST) ? '0 : idx + 1'b1;
        DRAIN: begin
          if (bus.x_ready) begin
            if (idx == ILAST) begin
              idx    <= '0;
              gnt    <= '0;
              rr_ptr <= rr_nxt;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Once converged the core streams every cycle, so CAPT never waits on out_valid.
  always_ff @(posedge clk) begin
    if (state == RUN && bus.core_out_valid) xbuf[0] <= bus.core_x;
    else if (state == CAPT)                 xbuf[idx] <= bus.core_x;
  end

`ifdef GSIM_SCHED_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == CLR) perf_cnt <= '0;
      else if (state == LOAD || state == RUN || state == CAPT) perf_cnt <= perf_cnt + 32'd1;
      if ((state == CAPT && state_n == DRAIN) || (state == RUN && state_n == IDLE))
        perf_cycles <= perf_cnt + 32'd1;
    end
  end
`endif

  assign bus.b_ready    = b_ready;
  assign bus.core_rst   = core_rst_q;
  assign bus.core_in_en = core_in_en;
  assign bus.core_b     = core_b;
  assign bus.x_data     = x_data;
  assign bus.x_valid    = x_valid;
  assign bus.x_last     = x_last;
  assign bus.x_tag      = x_tag;
  assign bus.err        = err_q;
  assign bus.err_tag    = err_tag_q;

endmodule

// File: tb/tb_gsim_sched.sv
// tb/tb_gsim_sched.sv - directed self-checking bench for gsim_sched
module tb_gsim_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset2;
  logic [1:0] req, gnt, req2, gnt2;
  int         n_run = 0;
  int         n_fail = 0;

  gsim_sched_if bif ();
  gsim_sched_if tif ();

`ifdef GSIM_SCHED_PERF_EN
  logic [31:0] perf1, perf2;
  gsim_sched dut (.clk(clk), .reset(reset), .req(req), .gnt(gnt), .bus(bif), .perf_cycles(perf1));
  gsim_sched #(.TIMEOUT(64)) dut_to (.clk(clk), .reset(reset2), .req(req2), .gnt(gnt2), .bus(tif), .perf_cycles(perf2));
`else
  gsim_sched dut (.clk(clk), .reset(reset), .req(req), .gnt(gnt), .bus(bif));
  gsim_sched #(.TIMEOUT(64)) dut_to (.clk(clk), .reset(reset2), .req(req2), .gnt(gnt2), .bus(tif));
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered and left at 1 time unit after a falling edge.
  task automatic run_job(input logic [1:0] reqv, input int exp_idx, input bit gaps,
                         input int stall_word, input int rst_word, input bit drop_req,
                         input logic [15:0] bbase, input logic [31:0] xbase);
    int cyc, beats, pulses, bad, w, stall;
    req = reqv;
    cyc = 0;
    do begin
      tick(); #1; cyc++;
    end while (gnt == 2'b00 && cyc < 20);
    check("gnt", gnt, 32'(1) << exp_idx);
    check("core_rst_clr", bif.core_rst, 1);
    if (drop_req) req = 2'b00;

    beats = 0; pulses = 0; bad = 0; cyc = 0;
    while (beats < 16 && cyc < 80) begin
      tick(); cyc++;
      bif.b_valid = gaps ? cyc[0] : 1'b1;
      bif.b_in    = bbase + 16'(beats);
      #1;
      if (cyc == 1) begin
        check("core_rst_load", bif.core_rst, 0);
        check("b_ready_load", bif.b_ready, 1);
      end
      if (bif.core_in_en !== bif.b_valid) bad++;
      if (bif.core_in_en === 1'b1) begin
        if (bif.core_b !== bbase + 16'(beats)) bad++;
        pulses++;
        beats++;
      end
    end
    check("load_beats", pulses, 16);
    check("load_align", bad, 0);

    tick(); bif.b_valid = 1'b1; #1;
    check("b_ready_run", bif.b_ready, 0);
    check("in_en_run", bif.core_in_en, 0);
    bif.b_valid = 1'b0;
    repeat (199) tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      bif.core_out_valid = 1'b1;
      bif.core_x         = xbase + 32'(k);
    end

    w = 0; stall = 0; cyc = 0;
    while (w < 16 && cyc < 100) begin
      tick(); cyc++;
      bif.core_out_valid = 1'b0;
      bif.x_ready = !(w == stall_word && stall < 5);
      #1;
      check($sformatf("x_valid[%0d]", w), bif.x_valid, 1);
      check($sformatf("x_data[%0d]", w), bif.x_data, xbase + 32'(w));
      check($sformatf("x_tag[%0d]", w), bif.x_tag, exp_idx);
      check($sformatf("x_last[%0d]", w), bif.x_last, (w == 15));
      if (w == rst_word) begin
        reset = 1'b1;
        #1;
        check("rst_x_valid", bif.x_valid, 0);
        check("rst_gnt", gnt, 0);
        check("rst_core_rst", bif.core_rst, 1);
        check("rst_err", bif.err, 0);
        return;
      end
      if (bif.x_ready) w++;
      else stall++;
    end
    check("drain_words", w, 16);
    if (stall_word >= 0) check("stall_cycles", stall, 5);
    bif.x_ready = 1'b1;
    tick(); #1;
    check("idle_x_valid", bif.x_valid, 0);
    check("idle_gnt", gnt, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    reset = 1'b1; reset2 = 1'b1; req = 2'b00; req2 = 2'b00;
    bif.b_in = 16'h0; bif.b_valid = 1'b1; bif.core_out_valid = 1'b0; bif.core_x = '0; bif.x_ready = 1'b1;
    tif.b_in = 16'h0; tif.b_valid = 1'b0; tif.core_out_valid = 1'b0; tif.core_x = '0; tif.x_ready = 1'b1;
    repeat (2) tick();
    #1;
    check("rst_gnt0", gnt, 0);
    check("rst_b_ready", bif.b_ready, 0);
    check("rst_core_in_en", bif.core_in_en, 0);
    check("rst_core_b", bif.core_b, 0);
    check("rst_x_valid0", bif.x_valid, 0);
    check("rst_x_last", bif.x_last, 0);
    check("rst_x_tag", bif.x_tag, 0);
    check("rst_err0", bif.err, 0);
    check("rst_err_tag", bif.err_tag, 0);
    check("rst_core_rst0", bif.core_rst, 1);
    reset = 1'b0; reset2 = 1'b0; bif.b_valid = 1'b0;
    tick(); #1;
    check("core_rst_release", bif.core_rst, 0);
    check("idle_no_req", gnt, 0);

    // single job
    run_job(2'b01, 0, 1'b0, -1, -1, 1'b0, 16'd1, 32'h100);
    req = 2'b00;
    reset = 1'b1; tick(); reset = 1'b0; #1;

    // round-robin with both requests held
    run_job(2'b11, 0, 1'b0, -1, -1, 1'b0, 16'h20, 32'h200);
    run_job(2'b11, 1, 1'b0, -1, -1, 1'b0, 16'h40, 32'h300);
    run_job(2'b11, 0, 1'b0, -1, -1, 1'b0, 16'h60, 32'h400);
    req = 2'b00;

    // gapped load
    run_job(2'b01, 0, 1'b1, -1, -1, 1'b0, 16'h80, 32'h500);
    req = 2'b00;

    // backpressure at word 7, request dropped mid-job
    run_job(2'b10, 1, 1'b0, 7, -1, 1'b1, 16'hA0, 32'h600);
    req = 2'b00;

    // timeout on the TIMEOUT=64 instance
    req2 = 2'b11;
    errs = 0;
    do begin
      tick(); #1; errs++;
    end while (gnt2 == 2'b00 && errs < 20);
    check("to_gnt", gnt2, 2'b01);
    for (int k = 0; k < 16; k++) begin
      tick(); tif.b_valid = 1'b1; tif.b_in = 16'(k);
    end
    tick(); tif.b_valid = 1'b0; #1;
    errs = 0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin tick(); #1; end
      if (tif.err === 1'b1) errs++;
    end
    check("err_early", errs, 0);
    tick(); #1;
    check("err_pulse", tif.err, 1);
    check("err_tag", tif.err_tag, 0);
    check("to_gnt_clear", gnt2, 0);
    tick(); #1;
    check("err_width", tif.err, 0);
    check("to_next_grant", gnt2, 2'b10);
    req2 = 2'b00; reset2 = 1'b1;

    // reset during drain, then a fresh job
    run_job(2'b01, 0, 1'b0, -1, 3, 1'b0, 16'hC0, 32'h700);
    req = 2'b00;
    tick(); reset = 1'b0; #1;
    run_job(2'b01, 0, 1'b0, -1, -1, 1'b0, 16'hE0, 32'h800);
    req = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/gsim_sched.md
Name: gsim_sched

Overview:
- Job scheduler and sequencer for the shared 16-unknown Gauss-Seidel solver core (gsim-style: in_en/b_in load, out_valid/x_out result stream).
- Arbitrates round-robin between NREQ requesters and clears the core between jobs.
- Streams each requester's 16-word b vector into the core and supervises convergence with a timeout.
- Captures the 16-word x result into a local buffer and drains it downstream with valid/ready backpressure, tagged with the owner.

Parameters:
- NREQ, 2, number of requesters (1..8).
- VEC_LEN, 16, words per b vector and per x result.
- TIMEOUT, 4096, max RUN-state cycles before a job is aborted.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester job request (level)
- gnt  output  NREQ  one-hot grant, held for the whole job
- b_in  input  16  shared b-vector word from the granted requester
- b_valid  input  1  b_in valid
- b_ready  output  1  scheduler accepts b word
- core_rst  output  1  synchronous clear to solver core
- core_in_en  output  1  core load strobe
- core_b  output  16  core b word
- core_out_valid  input  1  core converged, streaming x
- core_x  input  32  core x word
- x_data  output  32  result word
- x_valid  output  1  result valid
- x_ready  input  1  downstream accepts
- x_last  output  1  marks word VEC_LEN-1
- x_tag  output  3  requester index of the job
- err  output  1  one-cycle timeout pulse
- err_tag  output  3  requester index of the aborted job

Behaviour:
- Clock/reset: clk; reset asynchronous, active-high.
- Reset values: gnt=0, b_ready=0, core_in_en=0, core_b=0, x_valid=0, x_last=0, x_tag=0, err=0, err_tag=0, core_rst=1. State IDLE, rr pointer=0.
- core_rst is registered. It deasserts on the first clock edge after reset release, except when entering CLR.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from rr pointer, wrapping at NREQ.
  - gnt is registered and is high from the cycle after selection. Go to CLR.
  - With no req, stay in IDLE.
- CLR: core_rst=1 for exactly 1 cycle. Go to LOAD.
- LOAD:
  - b_ready=1. On each b_valid&b_ready beat: core_in_en=1 and core_b=b_in combinationally in the same cycle.
  - When b_valid=0: core_in_en=0, no gaps are inserted toward the core, and beat_cnt holds.
  - After beat VEC_LEN-1: b_ready drops next cycle, timeout counter clears, go to RUN.
- RUN: timeout counter increments each cycle.
  - core_out_valid=1: capture core_x into buf[0]; go to CAPT with idx=1.
  - Counter reaches TIMEOUT-1 without core_out_valid: err=1 for 1 cycle, err_tag=granted index, gnt cleared, rr pointer=granted+1, go to IDLE.
  - core_out_valid wins if it coincides with the timeout cycle.
- CAPT:
  - Capture core_x into buf[idx] on every cycle, regardless of core_out_valid (the core streams continuously once converged).
  - After idx=VEC_LEN-1, go to DRAIN with idx=0.
- DRAIN:
  - x_valid=1, x_data=buf[idx], x_tag=granted index, x_last=(idx==VEC_LEN-1).
  - idx advances only on x_valid&x_ready; data is stable while stalled.
  - On the last handshake: x_valid=0 next cycle, gnt cleared, rr pointer=granted+1 mod NREQ, go to IDLE.
  - Minimum one IDLE cycle between jobs.
- A requester dropping req mid-job has no effect; the job completes.
- b_valid outside LOAD is ignored; b_ready=0 there.
- Reset mid-job: immediate abort, all state back to reset values, no err pulse.
- Counter widths: beat/idx counters are clog2(VEC_LEN); timeout counter is clog2(TIMEOUT).

Optional Feature:
- Macro GSIM_SCHED_PERF_EN.
- When defined: output perf_cycles[31:0] is added.
  - A counter clears on the CLR cycle and counts every cycle through LOAD, RUN and CAPT.
  - It is latched into perf_cycles on entry to DRAIN, or on a timeout abort.
  - perf_cycles holds until the next latch; reset value 0.
- When undefined: no port and no counter; behaviour is otherwise identical.

Test Plan:
- Single job:
  - Stimulus: req=01, 16 contiguous b words 1..16; core model asserts out_valid 200 cycles into RUN with x words 0x100..0x10F.
  - Required response: gnt=01, one core_rst pulse, 16 core_in_en beats with core_b=1..16, then x_data 0x100..0x10F in order, x_tag=0, x_last only on the 16th word.
- Round-robin:
  - Stimulus: req=11 held continuously.
  - Required response: grants alternate 01,10,01; x_tag alternates 0,1,0; an IDLE cycle separates each job.
- Load gaps:
  - Stimulus: b_valid toggled every other cycle.
  - Required response: exactly 16 core_in_en pulses, each aligned with a beat; RUN entered only after the 16th beat.
- Backpressure:
  - Stimulus: x_ready low for 5 cycles at word 7.
  - Required response: x_data stays at word 7 during the stall, no words lost or duplicated, x_last on word 15.
- Timeout:
  - Stimulus: TIMEOUT=64, core never asserts out_valid.
  - Required response: err=1 for exactly one cycle, 64 cycles after RUN entry, with err_tag=granted index; gnt=0; next requester granted.
- Reset mid-DRAIN:
  - Stimulus: reset asserted at word 3.
  - Required response: x_valid=0 immediately, gnt=0, core_rst=1; a new job after release starts from word 0.
